imem_boot_loader: RTL

//  Sequences the Hack instruction memory (32K x 16 writable ROM image). It receives a program
//  as a byte stream from the UART receiver and writes it into the memory write port. The CPU
//  is held in reset for the whole load. After the load, the CPU fetch address (PC) owns the

---
 rtl/imem_boot_loader_pkg.sv | 31 +++
 rtl/imem_boot_loader_byte_timeout.sv | 42 ++++
 rtl/imem_boot_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared Hack memory widths and the boot-loader state encoding.
// Also holds the small state-decode helpers used by the loader FSM.
package imem_boot_loader_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_RELEASE = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERROR   = 3'd7
  } loader_state_e;

  function automatic logic takes_bytes(input loader_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

  function automatic logic is_timed(input loader_state_e s);
    return (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

  function automatic logic is_loading(input loader_state_e s);
    return (s != ST_RUN) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_timeout.sv
// Idle-cycle counter between received bytes; expired is asserted on the last allowed idle cycle.
// With TIMEOUT_CYCLES = 0 the expired output is constant low.
module imem_boot_loader_byte_timeout #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next idle count: cleared on request, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Idle count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && enable && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a big-endian length-prefixed program from the UART into the Hack instruction memory,
// holding the CPU in reset until the image is complete, then hands the read address to the PC.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W         = HACK_ADDR_W,
  parameter int TIMEOUT_CYCLES = 0,
  parameter bit BOOT_ON_RESET  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic                   load_req,
  input  logic [ADDR_W-1:0]      cpu_pc,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [HACK_WORD_W-1:0] imem_wdata,
  output logic                   imem_we,
  output logic                   cpu_reset,
  output logic                   loading,
  output logic                   load_done,
  output logic                   load_error,
  output logic [15:0]            words_loaded
);

  localparam loader_state_e RESET_STATE = BOOT_ON_RESET ? ST_LEN_HI : ST_RUN;

  loader_state_e          state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [7:0]             hi_q, hi_d;
  logic [HACK_WORD_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [15:0]            words_q, words_d;
  logic                   done_q, done_d;
  logic                   we_q, we_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic                   loading_q, loading_d;
  logic                   error_q, error_d;
  logic                   rx_ready_q, rx_ready_d;

  logic                   accept_s;
  logic [15:0]            len_s;
  logic                   expired_s;
  logic                   timer_clear_s;
  logic                   timer_en_s;

  // A byte racing a load_req is discarded.
  assign accept_s      = rx_valid && rx_ready_q && !load_req;
  assign len_s         = {count_q[15:8], rx_data};
  assign timer_en_s    = is_timed(state_q);
  assign timer_clear_s = accept_s || load_req || (state_d != state_q);

  imem_boot_loader_byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .expired(expired_s)
  );

  // Loader FSM next state, datapath updates and decoded output values.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    done_d  = done_q;
    if (load_req) begin
      state_d = ST_LEN_HI;
      addr_d  = '0;
      words_d = 16'd0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LEN_HI: begin
          if (accept_s) begin
            count_d[15:8] = rx_data;
            state_d       = ST_LEN_LO;
          end else begin
            state_d = ST_LEN_HI;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            count_d = len_s;
            if (len_s == 16'd0) begin
              state_d = ST_RELEASE;
            end else if (32'(len_s) > (32'd1 << ADDR_W)) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_DATA_HI;
            end
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_LEN_LO;
          end
        end
        ST_DATA_HI: begin
          if (accept_s) begin
            hi_d    = rx_data;
            state_d = ST_DATA_LO;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_LO: begin
          if (accept_s) begin
            wdata_d = {hi_q, rx_data};
            state_d = ST_WRITE;
          end else if (expired_s) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
        ST_WRITE: begin
          // Saturate so a full-depth load never wraps back onto word 0.
          if (addr_q != {ADDR_W{1'b1}}) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            addr_d = addr_q;
          end
          words_d = words_q + 16'd1;
          if ((words_q + 16'd1) == count_q) begin
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_RELEASE: begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
        ST_RUN:   state_d = ST_RUN;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ERROR;
      endcase
    end

    we_d        = (state_d == ST_WRITE);
    cpu_reset_d = (state_d != ST_RUN);
    loading_d   = is_loading(state_d);
    error_d     = (state_d == ST_ERROR);
    rx_ready_d  = takes_bytes(state_d);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      count_q     <= 16'd0;
      hi_q        <= 8'd0;
      wdata_q     <= '0;
      addr_q      <= '0;
      words_q     <= 16'd0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= BOOT_ON_RESET;
      loading_q   <= BOOT_ON_RESET;
      error_q     <= 1'b0;
      rx_ready_q  <= BOOT_ON_RESET;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      done_q      <= done_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      error_q     <= error_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  assign imem_addr    = (state_q == ST_RUN) ? cpu_pc : addr_q;
  assign imem_wdata   = wdata_q;
  assign imem_we      = we_q;
  assign cpu_reset    = cpu_reset_q;
  assign loading      = loading_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign rx_ready     = rx_ready_q;
  assign words_loaded = words_q;

endmodule
